axi_lite_arbiter: RTL and testbench
===================================

Name: axi_lite_arbiter

Overview:
- Shares one AXI4-lite slave port (unified memory/SRAM) between two masters: IFU (read-only) and LSU (read and write).
- Sits between the IFU/LSU AXI master ports and the memory slave.
- Grants one whole transaction at a time and holds the grant until the response handshake completes.
- Uses round-robin on ties, so neither fetch nor load/store can starve.

Parameters:
- ADDR_W, 32, address width of every ar/aw channel.
- DATA_W, 32, data width of r/w channels; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- ifu_araddr in ADDR_W; ifu_arvalid in 1; ifu_arready out 1  (IFU read-address channel).
- ifu_rdata out DATA_W; ifu_rresp out 2; ifu_rvalid out 1; ifu_rready in 1  (IFU read-data channel).
- lsu_araddr in ADDR_W; lsu_arvalid in 1; lsu_arready out 1  (LSU read-address channel).
- lsu_rdata out DATA_W; lsu_rresp out 2; lsu_rvalid out 1; lsu_rready in 1  (LSU read-data channel).
- lsu_awaddr in ADDR_W; lsu_awvalid in 1; lsu_awready out 1  (LSU write-address channel).
- lsu_wdata in DATA_W; lsu_wstrb in DATA_W/8; lsu_wvalid in 1; lsu_wready out 1  (LSU write-data channel).
- lsu_bresp out 2; lsu_bvalid out 1; lsu_bready in 1  (LSU write-response channel).
- slv_araddr out ADDR_W; slv_arvalid out 1; slv_arready in 1  (slave read-address channel).
- slv_rdata in DATA_W; slv_rresp in 2; slv_rvalid in 1; slv_rready out 1  (slave read-data channel).
- slv_awaddr out ADDR_W; slv_awvalid out 1; slv_awready in 1  (slave write-address channel).
- slv_wdata out DATA_W; slv_wstrb out DATA_W/8; slv_wvalid out 1; slv_wready in 1  (slave write-data channel).
- slv_bresp in 2; slv_bvalid in 1; slv_bready out 1  (slave write-response channel).

Behaviour:
- States:
  - IDLE.
  - GNT_IFU_R (IFU read owns the slave).
  - GNT_LSU_R (LSU read owns the slave).
  - GNT_LSU_W (LSU write owns the slave).
- Registers:
  - state, reset to IDLE.
  - last_gnt (0 = IFU, 1 = LSU), reset to 0, so LSU wins the first tie.
- Request terms:
  - ifu_req = ifu_arvalid.
  - lsu_rreq = lsu_arvalid.
  - lsu_wreq = lsu_awvalid | lsu_wvalid.
  - If lsu_rreq and lsu_wreq are both asserted, the LSU read wins and the write waits.
- IDLE transitions:
  - Exactly one master requesting: grant it.
  - Both requesting: grant the master that was not last_gnt.
  - LSU grant goes to GNT_LSU_R if lsu_rreq, else GNT_LSU_W.
  - last_gnt updates on entry to any grant state.
- Arbitration latency: exactly 1 cycle. The request is sampled in IDLE and the grant state is active the next cycle.
- In IDLE all master-side ready/valid outputs and all slave-side valid/ready outputs are 0. All slave-side data/address outputs are 0.
- Grant states: the granted master's channels pass combinationally to the slave, and the slave's channels pass combinationally back to that master. There is no added latency inside a grant.
- Non-granted master(s): all arready/awready/wready/rvalid/bvalid outputs are 0; data outputs are 0.
- GNT_LSU_W:
  - aw and w are forwarded independently; either order, or the same cycle, is legal.
  - slv_bready = lsu_bready.
- Release:
  - GNT_*_R goes to IDLE on the cycle after slv_rvalid & slv_rready.
  - GNT_LSU_W goes to IDLE on the cycle after slv_bvalid & slv_bready.
  - There is always one IDLE cycle between consecutive transactions.
- Transaction boundaries: a master deasserting valid before its ar/aw handshake is a protocol violation and has undefined result. The arbiter never preempts a granted transaction.
- Slave valid outside a grant: slv_rvalid or slv_bvalid asserted in IDLE is ignored and is not routed to any master.
- Reset mid-transaction: state goes to IDLE immediately and asynchronously, and all outputs go to 0. The slave is reset from the same rst, so no in-flight response survives.
- Response codes: rresp/bresp are forwarded unchanged; the arbiter does not interpret errors.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, GNT_IFU_R=2'd1, GNT_LSU_R=2'd2, GNT_LSU_W=2'd3).
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
- One natural sub-module, rr_pick2: a 2-requester round-robin picker (req[1:0], last_gnt → gnt[1:0]). It is combinational and reusable by a future MMIO crossbar.
- The FSM and channel muxes stay in axi_lite_arbiter.

Test Plan:
- IFU-only read:
  - Stimulus: ifu_arvalid=1, araddr=0x80000000; slave arready=1 next cycle; rvalid with rdata=0x00000413 two cycles later.
  - Required: ifu_arready pulses 1 cycle after request; ifu_rdata=0x00000413; state returns to IDLE the cycle after the r handshake.
- Simultaneous tie after reset:
  - Stimulus: ifu_arvalid and lsu_arvalid both held high.
  - Required: LSU is granted first; IFU is granted after the LSU r handshake plus 1 IDLE cycle; lsu_arready is never high while IFU is granted.
- LSU write with split handshakes:
  - Stimulus: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=4'b1111; slv_awready asserted 2 cycles before slv_wready; bvalid with bresp=OKAY 3 cycles later.
  - Required: slave sees the same addr/data/strb; lsu_bvalid asserted; IFU ar held off for the whole write.
- Starvation check:
  - Stimulus: IFU and LSU each request continuously for 8 transactions.
  - Required: grants alternate LSU, IFU, LSU, …; every request is granted within at most 2 transactions.
- Slow slave:
  - Stimulus: slv_rvalid delayed 10 cycles; slv_rresp=SLVERR.
  - Required: grant is held for all 10 cycles; ifu_rresp=2'b10 is passed through; no other master is granted meanwhile.
- Reset mid-write:
  - Stimulus: rst driven to 0 after the aw handshake but before the w handshake.
  - Required: all outputs are 0 in the same cycle; state=IDLE; after rst goes back to 1, an IFU read completes normally.

Source files
------------

// File: rtl/axi_lite_arbiter_pkg.sv
// axi_lite_arbiter_pkg: shared state encoding and AXI response codes for the IFU/LSU memory arbiter
package axi_lite_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_IFU_R = 2'd1,
        GNT_LSU_R = 2'd2,
        GNT_LSU_W = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_arbiter_if: one AXI4-lite port; master drives requests, slave drives responses
interface axi_lite_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin picker; on a tie the requester not granted last wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last_gnt);
    assign gnt[1] = req[1] & (~req[0] | ~last_gnt);

endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI4-lite memory slave between IFU (read) and LSU (read/write), one whole transaction per grant
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_arbiter_if.slave    ifu,
    axi_lite_arbiter_if.slave    lsu,
    axi_lite_arbiter_if.master   slv
);

    state_t     state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [1:0] gnt;
    logic       lsu_rreq, lsu_wreq, ifu_r, lsu_r, lsu_w;

    assign lsu_rreq = lsu.arvalid;
    assign lsu_wreq = lsu.awvalid | lsu.wvalid;
    assign ifu_r    = state == GNT_IFU_R;
    assign lsu_r    = state == GNT_LSU_R;
    assign lsu_w    = state == GNT_LSU_W;

    rr_pick2 u_pick (
        .req      ({lsu_rreq | lsu_wreq, ifu.arvalid}),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    // grant state and round-robin history; reset drops any in-flight grant at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // arbitrate only from IDLE, then hold the grant until the response handshake
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (gnt[1]) begin
                    state_nxt    = lsu_rreq ? GNT_LSU_R : GNT_LSU_W;
                    last_gnt_nxt = 1'b1;
                end else if (gnt[0]) begin
                    state_nxt    = GNT_IFU_R;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT_IFU_R, GNT_LSU_R: state_nxt = (slv.rvalid && slv.rready) ? IDLE : state;
            GNT_LSU_W:            state_nxt = (slv.bvalid && slv.bready) ? IDLE : state;
            default:              state_nxt = IDLE;
        endcase
    end

    assign slv.araddr  = ifu_r ? ifu.araddr : (lsu_r ? lsu.araddr : '0);
    assign slv.arvalid = (ifu_r & ifu.arvalid) | (lsu_r & lsu.arvalid);
    assign slv.rready  = (ifu_r & ifu.rready) | (lsu_r & lsu.rready);
    assign slv.awaddr  = lsu_w ? lsu.awaddr : '0;
    assign slv.awvalid = lsu_w & lsu.awvalid;
    assign slv.wdata   = lsu_w ? lsu.wdata : '0;
    assign slv.wstrb   = lsu_w ? lsu.wstrb : '0;
    assign slv.wvalid  = lsu_w & lsu.wvalid;
    assign slv.bready  = lsu_w & lsu.bready;

    assign ifu.arready = ifu_r & slv.arready;
    assign ifu.rvalid  = ifu_r & slv.rvalid;
    assign ifu.rdata   = ifu_r ? slv.rdata : '0;
    assign ifu.rresp   = ifu_r ? slv.rresp : '0;
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = '0;

    assign lsu.arready = lsu_r & slv.arready;
    assign lsu.rvalid  = lsu_r & slv.rvalid;
    assign lsu.rdata   = lsu_r ? slv.rdata : '0;
    assign lsu.rresp   = lsu_r ? slv.rresp : '0;
    assign lsu.awready = lsu_w & slv.awready;
    assign lsu.wready  = lsu_w & slv.wready;
    assign lsu.bvalid  = lsu_w & slv.bvalid;
    assign lsu.bresp   = lsu_w ? slv.bresp : '0;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scoreboard bench for the IFU/LSU arbiter
module tb_axi_lite_arbiter;
    import axi_lite_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_lite_arbiter_if ifu_bus ();
    axi_lite_arbiter_if lsu_bus ();
    axi_lite_arbiter_if slv_bus ();

    axi_lite_arbiter dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .slv (slv_bus)
    );

    typedef struct packed {
        logic        lsu;
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;
    logic who;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input logic l, input logic [31:0] a, input logic v);
        if (l) begin
            lsu_bus.arvalid = v;
            lsu_bus.araddr  = a;
        end else begin
            ifu_bus.arvalid = v;
            ifu_bus.araddr  = a;
        end
    endtask

    // caller has raised the master's arvalid; oth raises the other master's arvalid during the grant
    task automatic rd(input logic l, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                      input int lat, input logic oth, input logic [31:0] oa, output int cnt);
        state_t gs;
        exp_t   e;
        gs  = l ? GNT_LSU_R : GNT_IFU_R;
        cnt = 0;
        #1;
        while (!slv_bus.arvalid && cnt < 20) begin
            cyc();
            #1;
            cnt++;
        end
        chk("ar_fwd", {slv_bus.arvalid, slv_bus.araddr}, {1'b1, a});
        chk("gnt_state", dut.state, gs);
        slv_bus.arready = 1'b1;
        #1;
        chk("arready_route", {ifu_bus.arready, lsu_bus.arready}, {!l, l});
        cyc();
        set_ar(l, 32'h0, 1'b0);
        if (oth) set_ar(!l, oa, 1'b1);
        repeat (lat) begin
            #1;
            chk("r_hold", {dut.state, ifu_bus.arready, lsu_bus.arready, slv_bus.arvalid}, {gs, !l, l, 1'b0});
            cyc();
        end
        slv_bus.arready = 1'b0;
        slv_bus.rvalid  = 1'b1;
        slv_bus.rdata   = d;
        slv_bus.rresp   = r;
        sb.push_back(exp_t'{lsu: l, wr: 1'b0, data: d, resp: r});
        #1;
        e = sb.pop_front();
        chk("r_route", {ifu_bus.rvalid, lsu_bus.rvalid, ifu_bus.rdata, lsu_bus.rdata,
                        ifu_bus.rresp, lsu_bus.rresp, slv_bus.rready},
                       {!e.lsu, e.lsu, e.lsu ? 32'h0 : e.data, e.lsu ? e.data : 32'h0,
                        e.lsu ? 2'b00 : e.resp, e.lsu ? e.resp : 2'b00, 1'b1});
        cyc();
        slv_bus.rvalid = 1'b0;
        slv_bus.rdata  = 32'h0;
        slv_bus.rresp  = 2'b00;
        #1;
        chk("r_release", dut.state, IDLE);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int gap, input int blat, input logic [1:0] br);
        int   cnt;
        exp_t e;
        cnt = 0;
        lsu_bus.awaddr  = a;
        lsu_bus.awvalid = 1'b1;
        lsu_bus.wdata   = d;
        lsu_bus.wstrb   = s;
        lsu_bus.wvalid  = 1'b1;
        #1;
        while (!slv_bus.awvalid && cnt < 20) begin
            cyc();
            #1;
            cnt++;
        end
        chk("aw_lat", cnt, 1);
        chk("w_fwd", {slv_bus.awvalid, slv_bus.awaddr, slv_bus.wvalid, slv_bus.wdata, slv_bus.wstrb},
                     {1'b1, a, 1'b1, d, s});
        slv_bus.awready = 1'b1;
        #1;
        chk("awready", {lsu_bus.awready, lsu_bus.wready}, 2'b10);
        cyc();
        slv_bus.awready = 1'b0;
        lsu_bus.awvalid = 1'b0;
        lsu_bus.awaddr  = 32'h0;
        repeat (gap - 1) begin
            #1;
            chk("w_hold", {dut.state, slv_bus.arvalid, ifu_bus.arready, lsu_bus.wready, slv_bus.wvalid},
                          {GNT_LSU_W, 4'b0001});
            cyc();
        end
        slv_bus.wready = 1'b1;
        #1;
        chk("wready", {lsu_bus.wready, slv_bus.wdata, slv_bus.wstrb}, {1'b1, d, s});
        cyc();
        slv_bus.wready = 1'b0;
        lsu_bus.wvalid = 1'b0;
        lsu_bus.wdata  = 32'h0;
        lsu_bus.wstrb  = 4'h0;
        repeat (blat) begin
            #1;
            chk("b_wait", {dut.state, slv_bus.arvalid, lsu_bus.bvalid}, {GNT_LSU_W, 2'b00});
            cyc();
        end
        slv_bus.bvalid = 1'b1;
        slv_bus.bresp  = br;
        sb.push_back(exp_t'{lsu: 1'b1, wr: 1'b1, data: 32'h0, resp: br});
        #1;
        e = sb.pop_front();
        chk("b_route", {lsu_bus.bvalid, lsu_bus.bresp, slv_bus.bready, ifu_bus.rvalid},
                       {e.wr, e.resp, 1'b1, 1'b0});
        cyc();
        slv_bus.bvalid = 1'b0;
        slv_bus.bresp  = 2'b00;
        #1;
        chk("b_release", dut.state, IDLE);
    endtask

    initial begin
        ifu_bus.araddr = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 1; ifu_bus.awaddr = '0;
        ifu_bus.awvalid = 0; ifu_bus.wdata = '0; ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.bready = 0;
        lsu_bus.araddr = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 1; lsu_bus.awaddr = '0;
        lsu_bus.awvalid = 0; lsu_bus.wdata = '0; lsu_bus.wstrb = '0; lsu_bus.wvalid = 0; lsu_bus.bready = 1;
        slv_bus.arready = 0; slv_bus.rdata = '0; slv_bus.rresp = '0; slv_bus.rvalid = 0;
        slv_bus.awready = 0; slv_bus.wready = 0; slv_bus.bresp = '0; slv_bus.bvalid = 0;
        cyc();
        #1;
        chk("reset", {dut.state, slv_bus.arvalid, slv_bus.awvalid, slv_bus.wvalid, slv_bus.rready,
                      slv_bus.bready, slv_bus.araddr}, '0);
        cyc();
        rst = 1'b1;
        cyc();
        set_ar(1'b0, 32'h8000_0000, 1'b1);
        rd(1'b0, 32'h8000_0000, 32'h0000_0413, OKAY, 2, 1'b0, 32'h0, n);
        chk("ifu_lat", n, 1);
        cyc();
        slv_bus.rvalid = 1'b1;
        slv_bus.bvalid = 1'b1;
        slv_bus.rdata  = 32'hFFFF_FFFF;
        #1;
        chk("idle_ignore", {ifu_bus.rvalid, lsu_bus.rvalid, lsu_bus.bvalid, ifu_bus.rdata, lsu_bus.rdata,
                            slv_bus.rready, slv_bus.bready}, '0);
        cyc();
        slv_bus.rvalid = 1'b0;
        slv_bus.bvalid = 1'b0;
        slv_bus.rdata  = 32'h0;
        #1;
        chk("idle_stay", dut.state, IDLE);
        cyc();
        set_ar(1'b1, 32'h8000_0100, 1'b1);
        set_ar(1'b0, 32'h8000_0004, 1'b1);
        rd(1'b1, 32'h8000_0100, 32'hCAFE_0001, OKAY, 1, 1'b0, 32'h0, n);
        chk("tie_lsu_lat", n, 1);
        rd(1'b0, 32'h8000_0004, 32'h0000_0093, OKAY, 1, 1'b0, 32'h0, n);
        chk("tie_ifu_lat", n, 1);
        cyc();
        set_ar(1'b0, 32'h8000_0008, 1'b1);
        wr(32'h8000_1000, 32'hDEAD_BEEF, 4'b1111, 2, 2, OKAY);
        rd(1'b0, 32'h8000_0008, 32'h0000_0013, OKAY, 0, 1'b0, 32'h0, n);
        chk("after_wr_ifu_lat", n, 1);
        cyc();
        set_ar(1'b1, 32'h8000_2000, 1'b1);
        set_ar(1'b0, 32'h8000_0010, 1'b1);
        for (int i = 0; i < 8; i++) begin
            who = (i % 2 == 0);
            rd(who, who ? 32'h8000_2000 : 32'h8000_0010, 32'h0000_1000 + i, OKAY, i % 3, 1'b0, 32'h0, n);
            chk("starve_lat", n, 1);
            if (i < 6) set_ar(who, who ? 32'h8000_2000 : 32'h8000_0010, 1'b1);
        end
        cyc();
        set_ar(1'b0, 32'h8000_0020, 1'b1);
        rd(1'b0, 32'h8000_0020, 32'h0010_0093, SLVERR, 10, 1'b1, 32'h8000_3000, n);
        chk("slow_lat", n, 1);
        rd(1'b1, 32'h8000_3000, 32'h0000_55AA, OKAY, 1, 1'b0, 32'h0, n);
        chk("slow_next_lat", n, 1);
        cyc();
        wr(32'h8000_1004, 32'h1234_5678, 4'b0011, 1, 0, SLVERR);
        cyc();
        lsu_bus.awaddr  = 32'h8000_1008;
        lsu_bus.awvalid = 1'b1;
        lsu_bus.wdata   = 32'hA5A5_5A5A;
        lsu_bus.wstrb   = 4'b1111;
        lsu_bus.wvalid  = 1'b1;
        cyc();
        #1;
        chk("rst_w_gnt", {dut.state, slv_bus.awvalid}, {GNT_LSU_W, 1'b1});
        slv_bus.awready = 1'b1;
        cyc();
        slv_bus.awready = 1'b0;
        lsu_bus.awvalid = 1'b0;
        slv_bus.wready  = 1'b1;
        slv_bus.bvalid  = 1'b1;
        #1;
        chk("rst_w_live", {lsu_bus.wready, slv_bus.wvalid}, 2'b11);
        rst = 1'b0;
        #1;
        chk("rst_mid", {dut.state, slv_bus.wvalid, slv_bus.wdata, slv_bus.wstrb, lsu_bus.wready,
                        lsu_bus.bvalid, slv_bus.awaddr, slv_bus.bready}, '0);
        cyc();
        lsu_bus.wvalid = 1'b0;
        lsu_bus.wdata  = 32'h0;
        lsu_bus.wstrb  = 4'h0;
        lsu_bus.awaddr = 32'h0;
        slv_bus.wready = 1'b0;
        slv_bus.bvalid = 1'b0;
        rst = 1'b1;
        cyc();
        set_ar(1'b0, 32'h8000_0040, 1'b1);
        rd(1'b0, 32'h8000_0040, 32'h0000_0013, OKAY, 1, 1'b0, 32'h0, n);
        chk("post_rst_lat", n, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
